// File: rtl/lde_bank.sv
// lde_bank: clocked multi-channel gate-enabled capture bank (latch successor).
// Optional LDE_BANK_GSR_EN: glbl.GSR acts as an extra asynchronous reset.
module lde_bank #(
   parameter int unsigned               WIDTH    = 8,
   parameter int unsigned               CHANNELS = 4,
   parameter logic [WIDTH*CHANNELS-1:0] INIT     = '0,
   parameter logic                      G_INV    = 1'b1,
   parameter int unsigned               CNT_W    = 4
) (
   input  logic                      C,
   input  logic                      CLR_N,
   input  logic [WIDTH*CHANNELS-1:0] D,
   input  logic                      G,
   input  logic [CHANNELS-1:0]       GE,
   output logic [WIDTH*CHANNELS-1:0] Q,
   output logic [CHANNELS-1:0]       OPEN,
   output logic [CHANNELS-1:0]       CAPT,
   output logic [CNT_W*CHANNELS-1:0] CNT
);

   typedef enum logic {
      S_CLOSED = 1'b0,
      S_OPEN   = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic                      rst_n;
   logic                      gate_act;
   logic [CHANNELS-1:0]       open_w;
   state_e                    st_q [CHANNELS];
   state_e                    st_d [CHANNELS];
   logic [WIDTH*CHANNELS-1:0] q_q, q_d;
   logic [CHANNELS-1:0]       capt_q, capt_d;
   logic [CNT_W*CHANNELS-1:0] cnt_q, cnt_d;

`ifdef LDE_BANK_GSR_EN
   assign rst_n = CLR_N & ~glbl.GSR;
`else
   assign rst_n = CLR_N;
`endif

   assign gate_act = G_INV ? ~G : G;
   assign open_w   = {CHANNELS{gate_act}} & GE;

   // State register: window state, captured data, close pulse, counters.
   always_ff @(posedge C or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < CHANNELS; n++) st_q[n] <= S_CLOSED;
         q_q    <= INIT;
         capt_q <= '0;
         cnt_q  <= '0;
      end else begin
         st_q   <= st_d;
         q_q    <= q_d;
         capt_q <= capt_d;
         cnt_q  <= cnt_d;
      end
   end

   // Per-channel window FSM: follow D while open, pulse and count on close.
   always_comb begin
      st_d   = st_q;
      q_d    = q_q;
      capt_d = '0;
      cnt_d  = cnt_q;
      for (int n = 0; n < CHANNELS; n++) begin
         unique case (st_q[n])
            S_CLOSED: begin
               if (open_w[n]) begin
                  st_d[n]              = S_OPEN;
                  q_d[n*WIDTH +: WIDTH] = D[n*WIDTH +: WIDTH];
               end
            end
            S_OPEN: begin
               if (open_w[n]) begin
                  q_d[n*WIDTH +: WIDTH] = D[n*WIDTH +: WIDTH];
               end else begin
                  st_d[n]   = S_CLOSED;
                  capt_d[n] = 1'b1;
                  if (cnt_q[n*CNT_W +: CNT_W] != CNT_MAX)
                     cnt_d[n*CNT_W +: CNT_W] =
                        cnt_q[n*CNT_W +: CNT_W] + CNT_W'(1);
               end
            end
            default: st_d[n] = S_CLOSED;
         endcase
      end
   end

   // Window flags decoded straight from the state register.
   always_comb begin
      OPEN = '0;
      for (int n = 0; n < CHANNELS; n++) OPEN[n] = (st_q[n] == S_OPEN);
   end

   assign Q    = q_q;
   assign CAPT = capt_q;
   assign CNT  = cnt_q;

endmodule

// File: tb/tb_lde_bank.sv
// tb_lde_bank: directed and random checks of lde_bank against a model.
// Two instances cover active-low (CNT_W=2) and active-high gate polarity.
module tb_lde_bank;

   localparam logic [31:0] INIT0 = 32'hA5A5_5A5A;

   logic        C = 1'b0;
   logic        CLR_N;
   logic [31:0] D;
   logic        G, G2;
   logic [3:0]  GE;

   logic [31:0] q0, q1;
   logic [3:0]  op0, op1, cp0, cp1;
   logic [7:0]  cn0;
   logic [15:0] cn1;

   int errors = 0;
   int checks = 0;

   bit       m_open [2][4];
   bit       m_capt [2][4];
   logic [7:0] m_q  [2][4];
   int       m_cnt  [2][4];

   int exp_cnt [5] = '{1, 2, 3, 3, 3};

   always #5 C = ~C;

   lde_bank #(
      .WIDTH(8), .CHANNELS(4), .INIT(INIT0), .G_INV(1'b1), .CNT_W(2)
   ) u_dut (
      .C(C), .CLR_N(CLR_N), .D(D), .G(G), .GE(GE),
      .Q(q0), .OPEN(op0), .CAPT(cp0), .CNT(cn0)
   );

   lde_bank #(
      .WIDTH(8), .CHANNELS(4), .INIT(32'h0), .G_INV(1'b0), .CNT_W(4)
   ) u_pol (
      .C(C), .CLR_N(CLR_N), .D(D), .G(G2), .GE(GE),
      .Q(q1), .OPEN(op1), .CAPT(cp1), .CNT(cn1)
   );

   task automatic m_reset();
      for (int i = 0; i < 2; i++)
         for (int n = 0; n < 4; n++) begin
            m_open[i][n] = 0;
            m_capt[i][n] = 0;
            m_cnt[i][n]  = 0;
            m_q[i][n]    = (i == 0) ? INIT0[n*8 +: 8] : 8'h00;
         end
   endtask

   // Spec rules: open window loads D; closing pulses CAPT, bumps CNT.
   task automatic m_edge();
      bit en;
      int mx;
      if (!CLR_N) begin
         m_reset();
         return;
      end
      for (int i = 0; i < 2; i++)
         for (int n = 0; n < 4; n++) begin
            en = ((i == 0) ? !G : G2) && GE[n];
            mx = (i == 0) ? 3 : 15;
            if (en) begin
               m_q[i][n]    = D[n*8 +: 8];
               m_capt[i][n] = 0;
               m_open[i][n] = 1;
            end else begin
               m_capt[i][n] = m_open[i][n];
               if (m_open[i][n] && m_cnt[i][n] < mx) m_cnt[i][n]++;
               m_open[i][n] = 0;
            end
         end
   endtask

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] eq0, eq1;
      logic [3:0]  eo0, eo1, ec0, ec1;
      logic [7:0]  en0;
      logic [15:0] en1;
      for (int n = 0; n < 4; n++) begin
         eq0[n*8 +: 8] = m_q[0][n];
         eq1[n*8 +: 8] = m_q[1][n];
         eo0[n] = m_open[0][n];
         eo1[n] = m_open[1][n];
         ec0[n] = m_capt[0][n];
         ec1[n] = m_capt[1][n];
         en0[n*2 +: 2] = 2'(m_cnt[0][n]);
         en1[n*4 +: 4] = 4'(m_cnt[1][n]);
      end
      chk("q0", 64'(q0), 64'(eq0));
      chk("open0", 64'(op0), 64'(eo0));
      chk("capt0", 64'(cp0), 64'(ec0));
      chk("cnt0", 64'(cn0), 64'(en0));
      chk("q1", 64'(q1), 64'(eq1));
      chk("open1", 64'(op1), 64'(eo1));
      chk("capt1", 64'(cp1), 64'(ec1));
      chk("cnt1", 64'(cn1), 64'(en1));
   endtask

   task automatic step();
      @(posedge C);
      m_edge();
      #1;
      check_all();
   endtask

   initial begin
      CLR_N = 1'b0;
      D  = '0;
      G  = 1'b1;
      G2 = 1'b0;
      GE = '0;
      m_reset();
      repeat (3) step();
      chk("rst_q", 64'(q0), 64'(32'hA5A5_5A5A));
      chk("rst_cnt", 64'(cn0), 64'h0);
      CLR_N = 1'b1;

      // Transparency and hold on ch0.
      G = 1'b0; GE = 4'b0001; D = 32'h0000_0011; step();
      chk("tr_11", 64'(q0[7:0]), 64'h11);
      D = 32'h0000_0022; step();
      D = 32'h0000_0033; step();
      G = 1'b1; D = 32'h0000_0044; step();
      chk("tr_hold", 64'(q0[7:0]), 64'h33);
      chk("tr_capt", 64'(cp0), 64'h1);
      chk("tr_cnt", 64'(cn0[1:0]), 64'h1);
      chk("tr_oth", 64'(q0[31:8]), 64'hA5A55A);
      step();
      chk("tr_pulse", 64'(cp0), 64'h0);

      // Per-channel enable.
      G = 1'b0; GE = 4'b1010; D = 32'h1234_5678; step();
      GE = 4'b0010; step();
      chk("ge_capt", 64'(cp0), 64'h8);
      chk("ge_open", 64'(op0), 64'h2);
      chk("ge_ch2", 64'(q0[23:16]), 64'hA5);
      GE = 4'b0000; step();

      // Single-cycle windows and CNT saturation on ch2.
      for (int k = 0; k < 5; k++) begin
         GE = 4'b0100; D = $urandom; step();
         GE = 4'b0000; step();
         chk("sat_capt", 64'(cp0[2]), 64'h1);
         chk("sat_cnt", 64'(cn0[5:4]), 64'(exp_cnt[k]));
      end
      step();

      // Active-high polarity instance.
      G = 1'b1; G2 = 1'b1; GE = 4'hF; D = 32'hDEAD_BEEF; step();
      G2 = 1'b0; D = 32'h0; step();
      chk("pol_q", 64'(q1), 64'(32'hDEAD_BEEF));
      chk("pol_capt", 64'(cp1), 64'hF);
      step();
      chk("pol_pulse", 64'(cp1), 64'h0);

      // Reset asserted mid-window between edges.
      G = 1'b0; GE = 4'hF; D = 32'hCAFE_F00D; step();
      #2 CLR_N = 1'b0;
      m_reset();
      #1 check_all();
      chk("mid_q", 64'(q0), 64'(32'hA5A5_5A5A));
      step();
      chk("mid_capt", 64'(cp0), 64'h0);
      CLR_N = 1'b1;
      step();

      // Random traffic.
      for (int k = 0; k < 300; k++) begin
         D     = $urandom;
         G     = 1'($urandom_range(0, 1));
         G2    = 1'($urandom_range(0, 1));
         GE    = 4'($urandom);
         CLR_N = ($urandom_range(0, 49) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
